// File: rtl/clk_rst_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_gen_pkg
// Shared definitions for the clock-enable / reset sequencer:
//   - default divisor and delay-bit constants
//   - ch_width(): width of the channel-select field, never less than 1 bit
//   - rst_state_e: per-channel reset sequencer state
// -----------------------------------------------------------------------------
package clk_rst_gen_pkg;

    localparam int unsigned DEFAULT_DIVIDER   = 1000;
    localparam int unsigned DEFAULT_DELAY_BIT = 15;

    // A single channel still needs a 1-bit select port.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    typedef enum logic [1:0] {
        RST_HOLD      = 2'd0,  // waiting for the predecessor (or delay counter)
        RST_WAIT_TICK = 2'd1,  // predecessor released, waiting for own tick
        RST_RELEASED  = 2'd2   // reset deasserted until the next reset
    } rst_state_e;

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: counter 0..D, square-wave output toggling on every wrap,
// one-cycle tick on each rising transition, and a glitch-free divisor reload
// that only takes effect at a wrap.
//
// Optional feature macro: CLK_RST_GEN_DIV_LOAD_EN
//   defined   : runtime divisor reload through i_wr_en / i_wr_val
//   undefined : divisor fixed at DIVIDER, write inputs ignored, o_div_pending=0
//
// Ports:
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous active-high reset
//   i_wr_en        in   divisor write strobe for this channel
//   i_wr_val       in   new divisor
//   o_clk_out      out  divided square wave, period 2*(D+1)
//   o_tick_out     out  one-cycle strobe coincident with clk_out rising
//   o_div_pending  out  write accepted but not yet applied
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_rst_gen_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DIVIDER   = DEFAULT_DIVIDER
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [DIV_WIDTH-1:0] i_wr_val,
    output logic                 o_clk_out,
    output logic                 o_tick_out,
    output logic                 o_div_pending
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DIVIDER);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_clk;
    logic                 r_tick;
    logic [DIV_WIDTH-1:0] w_active;
    logic                 w_wrap;

    assign w_wrap = (r_cnt == w_active);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            // tick marks only the low->high transition
            r_tick <= ~r_clk;
        end else begin
            r_cnt  <= r_cnt + DIV_WIDTH'(1);
            r_tick <= 1'b0;
        end
    end

`ifdef CLK_RST_GEN_DIV_LOAD_EN
    logic [DIV_WIDTH-1:0] r_active;
    logic [DIV_WIDTH-1:0] r_pend;
    logic                 r_pend_vld;

    // The active divisor only changes on a wrap, so a period is never cut
    // short. A write landing on the wrap cycle bypasses the pending stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active   <= RESET_DIV;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_wrap) begin
            if (i_wr_en) begin
                r_active <= i_wr_val;
            end else if (r_pend_vld) begin
                r_active <= r_pend;
            end
            r_pend_vld <= 1'b0;
        end else if (i_wr_en) begin
            r_pend     <= i_wr_val;
            r_pend_vld <= 1'b1;
        end
    end

    assign w_active      = r_active;
    assign o_div_pending = r_pend_vld;
`else
    logic w_unused_wr;

    assign w_active      = RESET_DIV;
    assign o_div_pending = 1'b0;
    assign w_unused_wr   = ^{i_wr_en, i_wr_val};
`endif

    assign o_clk_out  = r_clk;
    assign o_tick_out = r_tick;

endmodule

// File: rtl/clk_rst_gen.sv
// -----------------------------------------------------------------------------
// clk_rst_gen
// NUM_CH independent clock-enable dividers plus an ordered reset release:
// channel 0 leaves reset when the delay counter reaches bit DELAY_BIT, each
// following channel leaves reset on its own first tick after its predecessor
// has been released. Dividers keep running while channels are held in reset.
//
// Optional feature macro: CLK_RST_GEN_DIV_LOAD_EN (runtime divisor reload;
// when undefined div_wr/div_ch/div_val are ignored and div_pending is 0).
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   div_wr       in   divisor write strobe
//   div_ch       in   target channel (values >= NUM_CH are ignored)
//   div_val      in   new divisor
//   clk_out      out  per-channel divided square wave
//   tick_out     out  per-channel strobe on clk_out rising transition
//   rst_out      out  per-channel active-high reset
//   div_pending  out  per-channel write accepted, not yet applied
//   rst_done     out  high one cycle after the last rst_out clears
// -----------------------------------------------------------------------------
module clk_rst_gen
    import clk_rst_gen_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 2,
    parameter  int unsigned DIV_WIDTH = 16,
    parameter  int unsigned DIVIDER   = DEFAULT_DIVIDER,
    parameter  int unsigned DELAY_BIT = DEFAULT_DELAY_BIT,
    localparam int unsigned CHW       = ch_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 div_wr,
    input  logic [CHW-1:0]       div_ch,
    input  logic [DIV_WIDTH-1:0] div_val,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick_out,
    output logic [NUM_CH-1:0]    rst_out,
    output logic [NUM_CH-1:0]    div_pending,
    output logic                 rst_done
);

    localparam int unsigned DW = DELAY_BIT + 1;

    logic [DW-1:0]     r_delay;
    logic [NUM_CH-1:0] w_wr;
    logic              r_rst_done;

    // Delay counter saturates as soon as its top bit is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay <= '0;
        end else if (!r_delay[DELAY_BIT]) begin
            r_delay <= r_delay + DW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            rst_state_e r_state;
            rst_state_e w_state_next;
            logic       r_rst;
            logic       w_prev_clear;
            logic       w_tick;

            // Out-of-range channel numbers simply match no instance.
            assign w_wr[gi] = div_wr && (div_ch == CHW'(gi));

            clk_div_channel #(
                .DIV_WIDTH (DIV_WIDTH),
                .DIVIDER   (DIVIDER)
            ) u_div (
                .clk           (clk),
                .reset         (reset),
                .i_wr_en       (w_wr[gi]),
                .i_wr_val      (div_val),
                .o_clk_out     (clk_out[gi]),
                .o_tick_out    (tick_out[gi]),
                .o_div_pending (div_pending[gi])
            );

            // Channel 0 is gated by the delay counter alone; later channels
            // wait for the predecessor and then their own tick.
            if (gi == 0) begin : g_first
                assign w_prev_clear = r_delay[DELAY_BIT];
                assign w_tick       = 1'b1;
            end else begin : g_next
                assign w_prev_clear = ~rst_out[gi-1];
                assign w_tick       = tick_out[gi];
            end

            always_comb begin
                w_state_next = r_state;
                unique case (r_state)
                    RST_HOLD: begin
                        if (w_prev_clear) begin
                            w_state_next = w_tick ? RST_RELEASED : RST_WAIT_TICK;
                        end
                    end
                    RST_WAIT_TICK: begin
                        if (w_tick) begin
                            w_state_next = RST_RELEASED;
                        end
                    end
                    RST_RELEASED: begin
                        w_state_next = RST_RELEASED;
                    end
                    default: begin
                        w_state_next = RST_HOLD;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= RST_HOLD;
                    r_rst   <= 1'b1;
                end else begin
                    r_state <= w_state_next;
                    r_rst   <= (w_state_next != RST_RELEASED);
                end
            end

            assign rst_out[gi] = r_rst;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= ~|rst_out;
        end
    end

    assign rst_done = r_rst_done;

endmodule

// File: tb/tb_clk_rst_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_gen
// Directed bench for clk_rst_gen with NUM_CH=2, DIVIDER=3, DELAY_BIT=4.
// Edge numbering: edge 0 is the first rising edge with reset low; values are
// sampled 1 time unit after each edge. Reload expectations follow the
// CLK_RST_GEN_DIV_LOAD_EN build option.
// -----------------------------------------------------------------------------
module tb_clk_rst_gen;

    localparam int unsigned NUM_CH    = 2;
    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIVIDER   = 3;
    localparam int unsigned DELAY_BIT = 4;

    logic                 clk     = 1'b0;
    logic                 reset   = 1'b1;
    logic                 div_wr  = 1'b0;
    logic [0:0]           div_ch  = 1'b0;
    logic [DIV_WIDTH-1:0] div_val = '0;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    tick_out;
    logic [NUM_CH-1:0]    rst_out;
    logic [NUM_CH-1:0]    div_pending;
    logic                 rst_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int e        = 0;

    clk_rst_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_WIDTH (DIV_WIDTH),
        .DIVIDER   (DIVIDER),
        .DELAY_BIT (DELAY_BIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div_wr      (div_wr),
        .div_ch      (div_ch),
        .div_val     (div_val),
        .clk_out     (clk_out),
        .tick_out    (tick_out),
        .rst_out     (rst_out),
        .div_pending (div_pending),
        .rst_done    (rst_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic step_to(input int t);
        while (e < t) step();
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s @edge %0d: got %b expected %b", tag, e, obs, exp);
        end
        $display("check %-14s edge %0d obs=%b exp=%b", tag, e, obs, exp);
    endtask

    initial begin
        // ---- reset state ----
        step();
        step();
        chk("rst_clk_out",  clk_out,            2'b00);
        chk("rst_tick",     tick_out,           2'b00);
        chk("rst_rst_out",  rst_out,            2'b11);
        chk("rst_pending",  div_pending,        2'b00);
        chk("rst_done0",    {1'b0, rst_done},   2'b00);

        // write while reset is high must be ignored
        div_wr = 1'b1; div_ch = 1'b1; div_val = 16'd0;
        step();
        chk("rstwr_pending", div_pending, 2'b00);
        div_wr = 1'b0;
        reset  = 1'b0;
        e      = -1;

        // ---- divider period and reset sequence ----
        step_to(0);  chk("pend_after_rel", div_pending, 2'b00);
        step_to(2);  chk("clk_e2",   clk_out,  2'b00);
                     chk("rsto_e2",  rst_out,  2'b11);
        step_to(3);  chk("clk_e3",   clk_out,  2'b11);
                     chk("tick_e3",  tick_out, 2'b11);
        step_to(4);  chk("clk_e4",   clk_out,  2'b11);
                     chk("tick_e4",  tick_out, 2'b00);
        step_to(7);  chk("clk_e7",   clk_out,  2'b00);
        step_to(11); chk("clk_e11",  clk_out,  2'b11);
                     chk("tick_e11", tick_out, 2'b11);
        step_to(12); chk("tick_e12", tick_out, 2'b00);
        step_to(15); chk("rsto_e15", rst_out,  2'b11);
        step_to(16); chk("rsto_e16", rst_out,  2'b10);
                     chk("done_e16", {1'b0, rst_done}, 2'b00);
        step_to(19); chk("rsto_e19", rst_out,  2'b10);
                     chk("tick_e19", tick_out, 2'b11);
        step_to(20); chk("rsto_e20", rst_out,  2'b00);
                     chk("done_e20", {1'b0, rst_done}, 2'b00);
        step_to(21); chk("done_e21", {1'b0, rst_done}, 2'b01);

`ifdef CLK_RST_GEN_DIV_LOAD_EN
        // ---- mid-period reload of ch1 to D=0 ----
        div_wr = 1'b1; div_ch = 1'b1; div_val = 16'd0;
        step_to(22); div_wr = 1'b0;
                     chk("pend1_set",  div_pending, 2'b10);
        step_to(23); chk("pend1_clr",  div_pending, 2'b00);
                     chk("clk1_e23",   {1'b0, clk_out[1]},  2'b00);
        step_to(24); chk("clk1_e24",   {1'b0, clk_out[1]},  2'b01);
                     chk("tick1_e24",  {1'b0, tick_out[1]}, 2'b01);
        step_to(25); chk("clk1_e25",   {1'b0, clk_out[1]},  2'b00);
                     chk("tick1_e25",  {1'b0, tick_out[1]}, 2'b00);
        step_to(26); chk("clk1_e26",   {1'b0, clk_out[1]},  2'b01);
                     chk("tick1_e26",  {1'b0, tick_out[1]}, 2'b01);

        // ---- ch0 write exactly on its wrap cycle ----
        div_wr = 1'b1; div_ch = 1'b0; div_val = 16'd7;
        step_to(27); div_wr = 1'b0;
                     chk("pend0_wrap", div_pending, 2'b00);
                     chk("clk0_e27",   {1'b0, clk_out[0]},  2'b01);
                     chk("tick0_e27",  {1'b0, tick_out[0]}, 2'b01);
        step_to(34); chk("clk0_e34",   {1'b0, clk_out[0]},  2'b01);
        step_to(35); chk("clk0_e35",   {1'b0, clk_out[0]},  2'b00);
        step_to(42); chk("clk0_e42",   {1'b0, clk_out[0]},  2'b00);
        step_to(43); chk("clk0_e43",   {1'b0, clk_out[0]},  2'b01);
                     chk("tick0_e43",  {1'b0, tick_out[0]}, 2'b01);
`else
        // ---- writes ignored without the reload feature ----
        div_wr = 1'b1; div_ch = 1'b0; div_val = 16'd0;
        step_to(22); div_wr = 1'b0;
                     chk("pend_fixed", div_pending, 2'b00);
        step_to(23); chk("clk0_e23",   {1'b0, clk_out[0]},  2'b00);
        step_to(24); chk("clk0_e24",   {1'b0, clk_out[0]},  2'b00);
        step_to(26); chk("clk0_e26",   {1'b0, clk_out[0]},  2'b00);
        step_to(27); chk("clk0_e27",   {1'b0, clk_out[0]},  2'b01);
                     chk("tick0_e27",  {1'b0, tick_out[0]}, 2'b01);
        step_to(31); chk("clk0_e31",   {1'b0, clk_out[0]},  2'b00);
        step_to(43); chk("clk0_e43",   {1'b0, clk_out[0]},  2'b01);
                     chk("tick0_e43",  {1'b0, tick_out[0]}, 2'b01);
`endif

        // ---- reset with a pending write ----
        div_wr = 1'b1; div_ch = 1'b0; div_val = 16'd1;
        step_to(44); div_wr = 1'b0;
`ifdef CLK_RST_GEN_DIV_LOAD_EN
        chk("pend0_e44", div_pending, 2'b01);
`else
        chk("pend0_e44", div_pending, 2'b00);
`endif
        reset = 1'b1;
        step_to(45);
        chk("mid_rst_out",  rst_out,     2'b11);
        chk("mid_clk_out",  clk_out,     2'b00);
        chk("mid_tick",     tick_out,    2'b00);
        chk("mid_pending",  div_pending, 2'b00);
        chk("mid_done",     {1'b0, rst_done}, 2'b00);
        reset = 1'b0;
        e     = -1;

        step_to(0);  chk("re_pend_e0", div_pending, 2'b00);
        step_to(2);  chk("re_clk_e2",  clk_out,  2'b00);
        step_to(3);  chk("re_clk_e3",  clk_out,  2'b11);
                     chk("re_tick_e3", tick_out, 2'b11);
        step_to(6);  chk("re_clk_e6",  clk_out,  2'b11);
        step_to(7);  chk("re_clk_e7",  clk_out,  2'b00);
        step_to(11); chk("re_clk_e11", clk_out,  2'b11);
                     chk("re_rst_e11", rst_out,  2'b11);
        step_to(16); chk("re_rst_e16", rst_out,  2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
